// File: rtl/timer_pkg.sv
// Shared types and constants for the 8-bit timer control block.
// Holds the FSM encoding, the TCR/TSR bit positions and the CKS-to-period mapping.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_e;

    localparam int TCR_LOAD   = 7;
    localparam int TCR_EN     = 4;
    localparam int TCR_DIR    = 3;
    localparam int TCR_CKS_HI = 1;
    localparam int TCR_CKS_LO = 0;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    localparam int DIV_W = 4;

    // Tick period in pclk cycles produced by a given CKS setting.
    function automatic int unsigned cks_period(input logic [1:0] cks);
        return 32'd2 << cks;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler producing the counter tick clk_in from a 4-bit divider.
// The divider is held at zero outside RUN so every RUN entry starts a fresh tick period.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       run,
    input  logic [1:0] cks,
    output logic       clk_in
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = '0;
        if (run) begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign clk_in = run & div_q[cks];

endmodule

// File: rtl/timer_ctrl.sv
// Timer control/status: mode FSM, wrap detection on the counter value,
// write-1-to-clear sticky flags and the registered interrupt.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic [7:0]       tcr,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       tier,
    input  logic             tsr_wr,
    input  logic [1:0]       tsr_wdata,
    output logic             clk_in,
    output logic [1:0]       tsr,
    output logic             irq,
    output logic [1:0]       state
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_prev_q;
    logic [CNT_W-1:0] cnt_prev_d;
    logic [1:0]       tsr_q;
    logic [1:0]       tsr_d;
    logic             irq_q;
    logic             irq_d;
    logic [1:0]       evt;
    logic             run;

    logic unused_tcr;
    assign unused_tcr = ^{tcr[6:5], tcr[2]};

    assign run = (state_q == RUN);

    // LOAD has priority from any state; the encoding 3 falls back to IDLE.
    always_comb begin
        state_d = IDLE;
        if (tcr[TCR_LOAD]) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                IDLE, RUN, LOAD: state_d = tcr[TCR_EN] ? RUN : IDLE;
                default:         state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_prev_d    = cnt;
        evt           = '0;
        evt[TSR_OVF]  = run & ~tcr[TCR_DIR] & (cnt_prev_q == '1) & (cnt == '0);
        evt[TSR_UDF]  = run &  tcr[TCR_DIR] & (cnt_prev_q == '0) & (cnt == '1);
        tsr_d         = evt | (tsr_q & ~(tsr_wdata & {2{tsr_wr}}));
        irq_d         = |(tsr_q & tier);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q    <= IDLE;
            cnt_prev_q <= '0;
            tsr_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_prev_q <= cnt_prev_d;
            tsr_q      <= tsr_d;
            irq_q      <= irq_d;
        end
    end

    timer_prescaler u_prescaler (
        .pclk     (pclk),
        .preset_n (preset_n),
        .run      (run),
        .cks      (tcr[TCR_CKS_HI:TCR_CKS_LO]),
        .clk_in   (clk_in)
    );

    assign tsr   = tsr_q;
    assign irq   = irq_q;
    assign state = state_q;

endmodule
